// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the memory (slave).
// rdata answers a request MEM_LAT cycles after it was issued.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output req, output addr, input rdata);
    modport slave  (input req, input addr, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues one imem read per cycle, tags each in-flight read with its pc,
// squashes wrong-path reads on branch, and stops fetching on the halt word.
module instr_fetch_unit #(
    parameter int unsigned MEM_LAT   = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic [2:0]         branch,
    output logic [31:0]        pc_4,
    output logic               readIn,
    instr_fetch_unit_if.master imem,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               halted,
    output logic [31:0]        instr_count
);
    logic [MEM_LAT-1:0] tag_v_q, tag_v_d;
    logic [31:0]        tag_pc_q [MEM_LAT];
    logic               halted_q, valid_q;
    logic [31:0]        instr_q, instr_pc_q, count_q;
    logic               squash, tail_v, halt_hit, deliver;
    logic [31:0]        tail_pc;

    assign pc_4      = pc + 32'd4;
    assign imem.req  = ~halted_q & ~rst;
    assign imem.addr = {pc[31:2], 2'b00};

    assign tail_v  = tag_v_q[MEM_LAT-1];
    assign tail_pc = tag_pc_q[MEM_LAT-1];
    // A branch outranks a halt word sitting at the tail: that word is wrong-path.
    assign squash   = (branch != 3'd0) & ~halted_q;
    assign halt_hit = tail_v & ~squash & (imem.rdata == HALT_WORD);
    assign deliver  = tail_v & ~squash & (imem.rdata != HALT_WORD);

    always_comb begin
        tag_v_d = '0;
        if (!squash && !halt_hit) begin
            tag_v_d[0] = imem.req;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_v_d[i] = tag_v_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q    <= '0;
            halted_q   <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            tag_v_q <= tag_v_d;
            valid_q <= deliver;
            if (halt_hit) begin
                halted_q <= 1'b1;
            end
            if (deliver) begin
                instr_q    <= imem.rdata;
                instr_pc_q <= tail_pc;
                count_q    <= count_q + 32'd1;
            end
        end
    end

    // Tag addresses carry no meaning without their valid bit, so they skip reset.
    always_ff @(posedge clk) begin
        tag_pc_q[0] <= imem.addr;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            tag_pc_q[i] <= tag_pc_q[i-1];
        end
    end

    assign readIn      = ~halted_q;
    assign halted      = halted_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_count = count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory with fixed read latency plus a queue-based
// reference model of which requests survive to delivery.
module tb_instr_fetch_unit;
    localparam int unsigned L    = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [2:0]  branch;
    logic [31:0] pc_4;
    logic        readIn;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        halted;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .MEM_LAT   (L),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .branch      (branch),
        .pc_4        (pc_4),
        .readIn      (readIn),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    typedef struct { logic v; logic [31:0] a; } mreq_t;
    mreq_t mp[$];

    typedef struct { int unsigned cyc; logic [31:0] pc; } pend_t;
    pend_t pend[$];
    int unsigned cyc_n;

    logic        e_valid, e_halted, e_req;
    logic [31:0] e_instr, e_pc, e_count;
    logic        a_req;
    logic [31:0] a_addr, a_pc4;

    function automatic void fill_mem();
        for (int k = 0; k < 256; k++) mem[k] = 32'(k);
    endfunction

    // A request survives iff no reset or branch occurs from its issue cycle up to and
    // including the cycle its data returns, and its word is not the halt word.
    task automatic model_step(input logic r, input logic [2:0] br, input logic [31:0] p);
        logic        halt_now;
        logic [31:0] w;
        pend_t       h, n;
        halt_now = 1'b0;
        e_req    = !e_halted && !r;
        e_valid  = 1'b0;
        if (r) begin
            pend.delete();
            e_instr  = '0;
            e_pc     = '0;
            e_count  = '0;
            e_halted = 1'b0;
        end else begin
            if (br != 3'd0 && !e_halted) begin
                pend.delete();
            end else if (pend.size() > 0) begin
                h = pend[0];
                if (h.cyc + L == cyc_n) begin
                    w = mem[h.pc[9:2]];
                    if (w == HALT) begin
                        halt_now = 1'b1;
                        e_halted = 1'b1;
                        pend.delete();
                    end else begin
                        e_valid = 1'b1;
                        e_instr = w;
                        e_pc    = h.pc;
                        e_count = e_count + 32'd1;
                        void'(pend.pop_front());
                    end
                end
            end
            if (e_req && br == 3'd0 && !halt_now) begin
                n.cyc = cyc_n;
                n.pc  = {p[31:2], 2'b00};
                pend.push_back(n);
            end
        end
        cyc_n++;
    endtask

    // One clock cycle: drive inputs and memory data, sample combinational outputs,
    // advance the model, then step past the edge.
    task automatic tick(input logic r, input logic [2:0] br, input logic [31:0] p);
        mreq_t m, nm;
        rst    = r;
        branch = br;
        pc     = p;
        m      = mp[0];
        if (m.v) bus.rdata = mem[m.a[9:2]];
        else     bus.rdata = $urandom;
        #1;
        a_req  = bus.req;
        a_addr = bus.addr;
        a_pc4  = pc_4;
        model_step(r, br, p);
        @(posedge clk);
        #1;
        void'(mp.pop_front());
        nm.v = a_req;
        nm.a = a_addr;
        mp.push_back(nm);
    endtask

    task automatic test_reset();
        tick(1'b1, 3'd0, 32'd0);
        tick(1'b1, 3'd0, 32'd0);
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 ||
            instr_count !== 32'd0 || halted !== 1'b0 || readIn !== 1'b1 || a_req !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b i=%h pc=%h cnt=%0d h=%b rd=%b req=%b want 0 0 0 0 0 1 0",
                     instr_valid, instr, instr_pc, instr_count, halted, readIn, a_req);
        end
    endtask

    task automatic test_straight();
        fill_mem();
        tick(1'b1, 3'd0, 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 3'd0, 32'(c * 4));
            checks++;
            if (instr_valid !== e_valid || instr !== e_instr || instr_pc !== e_pc ||
                instr_count !== e_count || readIn !== 1'b1) begin
                errors++;
                $display("FAIL straight cyc%0d: got v=%b pc=%h i=%h cnt=%0d rd=%b want v=%b pc=%h i=%h cnt=%0d rd=1",
                         c + 1, instr_valid, instr_pc, instr, instr_count, readIn,
                         e_valid, e_pc, e_instr, e_count);
            end
            if (c >= 2) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== 32'(c - 2)) begin
                    errors++;
                    $display("FAIL straight_seq cyc%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                             c + 1, instr_valid, instr_pc, instr, 32'(4 * (c - 2)), 32'(c - 2));
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] cur;
        logic [2:0]  br;
        logic        wrong;
        fill_mem();
        tick(1'b1, 3'd0, 32'd0);
        cur   = 32'd0;
        wrong = 1'b0;
        for (int c = 0; c < 13; c++) begin
            br = (c == 5) ? 3'b001 : 3'd0;
            tick(1'b0, br, cur);
            cur = (br != 3'd0) ? 32'h40 : cur + 32'd4;
            if (instr_valid === 1'b1 && instr_pc >= 32'hC && instr_pc < 32'h40) wrong = 1'b1;
            checks++;
            if (instr_valid !== e_valid || instr !== e_instr || instr_pc !== e_pc ||
                instr_count !== e_count) begin
                errors++;
                $display("FAIL branch cyc%0d: got v=%b pc=%h i=%h cnt=%0d want v=%b pc=%h i=%h cnt=%0d",
                         c + 1, instr_valid, instr_pc, instr, instr_count,
                         e_valid, e_pc, e_instr, e_count);
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL branch_bubble cyc%0d: got v=%b want v=0", c + 1, instr_valid);
                end
            end
            if (c == 8) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h10) begin
                    errors++;
                    $display("FAIL branch_target: got v=%b pc=%h i=%h want v=1 pc=00000040 i=00000010",
                             instr_valid, instr_pc, instr);
                end
            end
        end
        checks++;
        if (wrong) begin
            errors++;
            $display("FAIL branch_wrong_path: got wrong-path delivery=1 want 0");
        end
    endtask

    task automatic test_halt();
        logic [31:0] cur, p;
        logic        seen;
        fill_mem();
        mem[4] = HALT;
        tick(1'b1, 3'd0, 32'd0);
        cur  = 32'd0;
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            p = readIn ? cur : 32'h7F;
            tick(1'b0, (c == 10) ? 3'b010 : 3'd0, p);
            cur = p + 32'd4;
            if (instr_valid === 1'b1 && instr_pc === 32'h10) seen = 1'b1;
            checks++;
            if (instr_valid !== e_valid || instr !== e_instr || instr_pc !== e_pc ||
                instr_count !== e_count || halted !== e_halted || readIn !== !e_halted) begin
                errors++;
                $display("FAIL halt cyc%0d: got v=%b pc=%h cnt=%0d h=%b rd=%b want v=%b pc=%h cnt=%0d h=%b",
                         c + 1, instr_valid, instr_pc, instr_count, halted, readIn,
                         e_valid, e_pc, e_count, e_halted);
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (halted !== (c == 6)) begin
                    errors++;
                    $display("FAIL halt_timing cyc%0d: got h=%b want %b", c + 1, halted, c == 6);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || readIn !== 1'b0 || instr_count !== 32'd4 || a_req !== 1'b0 ||
            a_pc4 !== 32'h83 || seen) begin
            errors++;
            $display("FAIL halt_final: got h=%b rd=%b cnt=%0d req=%b pc4=%h seen10=%b want 1 0 4 0 00000083 0",
                     halted, readIn, instr_count, a_req, a_pc4, seen);
        end
        mem[4] = 32'd4;
    endtask

    task automatic test_branch_halt();
        logic [31:0] cur;
        logic [2:0]  br;
        fill_mem();
        mem[4] = HALT;
        tick(1'b1, 3'd0, 32'd0);
        checks++;
        if (halted !== 1'b0 || readIn !== 1'b1) begin
            errors++;
            $display("FAIL halt_cleared_by_reset: got h=%b rd=%b want h=0 rd=1", halted, readIn);
        end
        cur = 32'd0;
        for (int c = 0; c < 14; c++) begin
            br = (c == 6) ? 3'b100 : 3'd0;
            tick(1'b0, br, cur);
            cur = (br != 3'd0) ? 32'h80 : cur + 32'd4;
            checks++;
            if (instr_valid !== e_valid || instr !== e_instr || instr_pc !== e_pc ||
                instr_count !== e_count || halted !== 1'b0 || readIn !== 1'b1) begin
                errors++;
                $display("FAIL branch_halt cyc%0d: got v=%b pc=%h cnt=%0d h=%b rd=%b want v=%b pc=%h cnt=%0d h=0 rd=1",
                         c + 1, instr_valid, instr_pc, instr_count, halted, readIn,
                         e_valid, e_pc, e_count);
            end
            if (c == 9) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin
                    errors++;
                    $display("FAIL branch_halt_target: got v=%b pc=%h want v=1 pc=00000080",
                             instr_valid, instr_pc);
                end
            end
        end
        mem[4] = 32'd4;
    endtask

    task automatic test_reset_mid();
        fill_mem();
        tick(1'b1, 3'd0, 32'd0);
        for (int c = 0; c < 6; c++) tick(1'b0, 3'd0, 32'(c * 4));
        tick(1'b1, 3'd0, 32'h18);
        checks++;
        if (instr_valid !== 1'b0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got v=%b cnt=%0d want v=0 cnt=0", instr_valid, instr_count);
        end
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 3'd0, 32'(c * 4));
            checks++;
            if (instr_valid !== e_valid || instr_pc !== e_pc || instr_count !== e_count) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got v=%b pc=%h cnt=%0d want v=%b pc=%h cnt=%0d",
                         c + 1, instr_valid, instr_pc, instr_count, e_valid, e_pc, e_count);
            end
            if (c <= 2) begin
                checks++;
                if (instr_valid !== (c == 2) || (c == 2 && (instr_pc !== 32'd0 || instr_count !== 32'd1))) begin
                    errors++;
                    $display("FAIL reset_mid_first cyc%0d: got v=%b pc=%h cnt=%0d want v=%b pc=0 cnt=1",
                             c + 1, instr_valid, instr_pc, instr_count, c == 2);
                end
            end
        end
    endtask

    task automatic test_pc4();
        logic [31:0] p;
        fill_mem();
        tick(1'b1, 3'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            p = (i == 0) ? 32'hFFFF_FFFC : $urandom;
            tick(1'b0, 3'd0, p);
            checks++;
            if (a_pc4 !== p + 32'd4 || a_addr !== {p[31:2], 2'b00} || a_req !== 1'b1 ||
                (i == 0 && a_pc4 !== 32'd0)) begin
                errors++;
                $display("FAIL pc4 pc=%h: got pc4=%h addr=%h req=%b want pc4=%h addr=%h req=1",
                         p, a_pc4, a_addr, a_req, p + 32'd4, {p[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] cur, p;
        logic [2:0]  br;
        logic        r;
        for (int k = 0; k < 256; k++) mem[k] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
        tick(1'b1, 3'd0, 32'd0);
        cur = 32'd0;
        for (int c = 0; c < 600; c++) begin
            r  = halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 80) == 0);
            br = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            p  = readIn ? cur : 32'h7F;
            tick(r, br, p);
            if (r) cur = 32'd0;
            else if (br != 3'd0) cur = 32'($urandom_range(0, 1023));
            else cur = p + 32'd4;
            checks++;
            if (instr_valid !== e_valid || instr !== e_instr || instr_pc !== e_pc ||
                instr_count !== e_count || halted !== e_halted || readIn !== !e_halted ||
                a_req !== e_req || (e_req && a_addr !== {p[31:2], 2'b00})) begin
                errors++;
                $display("FAIL random cyc%0d: got v=%b pc=%h i=%h cnt=%0d h=%b req=%b want v=%b pc=%h i=%h cnt=%0d h=%b req=%b",
                         c, instr_valid, instr_pc, instr, instr_count, halted, a_req,
                         e_valid, e_pc, e_instr, e_count, e_halted, e_req);
            end
        end
    endtask

    initial begin
        mreq_t z;
        rst       = 1'b1;
        branch    = 3'd0;
        pc        = 32'd0;
        bus.rdata = 32'd0;
        cyc_n     = 0;
        e_valid   = 1'b0;
        e_halted  = 1'b0;
        e_req     = 1'b0;
        e_instr   = '0;
        e_pc      = '0;
        e_count   = '0;
        z.v       = 1'b0;
        z.a       = '0;
        for (int i = 0; i < L; i++) mp.push_back(z);
        fill_mem();
        test_reset();
        test_straight();
        test_branch();
        test_halt();
        test_branch_halt();
        test_reset_mid();
        test_pc4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
